// File: rtl/expander_feeder_if.sv
// rtl/expander_feeder_if.sv - word-load stream and run-side outputs of the SHA-256 expander feeder
interface expander_feeder_if;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [31:0] wr_data_i;
    logic        wr_last_i;
    logic        send_o;
    logic [31:0] data_o;
    logic        run_o;
    logic [1:0]  lane_o;
    logic [5:0]  word_o;
    logic [3:0]  lane_mask_o;
    logic        done_o;

    // Feeder side: consumes the load stream, drives the run outputs.
    modport slave (
        input  wr_valid_i, wr_data_i, wr_last_i,
        output wr_ready_o, send_o, data_o, run_o, lane_o, word_o, lane_mask_o, done_o
    );

    // Host / expander side.
    modport master (
        output wr_valid_i, wr_data_i, wr_last_i,
        input  wr_ready_o, send_o, data_o, run_o, lane_o, word_o, lane_mask_o, done_o
    );
endinterface

// File: rtl/expander_feeder.sv
// rtl/expander_feeder.sv - buffers up to 4 message blocks and replays them lane-interleaved to the expander
module expander_feeder #(
    parameter int LANES  = 4,
    parameter int WORDS  = 16,
    parameter int ROUNDS = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    expander_feeder_if.slave  bus
);
    localparam int DEPTH   = LANES * WORDS;
    localparam int RUN_LEN = LANES * ROUNDS;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic [4:0]  cnt [LANES];
    logic [5:0]  ptr;
    logic [7:0]  c;

    logic        accept;
    logic [1:0]  c_lane;
    logic [5:0]  c_word;
    logic [31:0] rd_word;
    logic        hit;
    logic [3:0]  mask_next;

    assign accept  = (state == S_LOAD) && bus.wr_ready_o && bus.wr_valid_i;
    assign c_lane  = c[1:0];
    assign c_word  = c[7:2];
    assign rd_word = mem[{c_lane, c_word[3:0]}];
    // Words beyond the lane's count were never written this load and must read as zero.
    assign hit     = c_word < {1'b0, cnt[c_lane]};

    // Lane occupancy including the word being accepted on the exit cycle.
    always_comb begin
        mask_next = '0;
        for (int l = 0; l < LANES; l++) begin
            mask_next[l] = (cnt[l] != 5'd0) || (ptr[5:4] == 2'(l));
        end
    end

    // Message buffer; contents need no reset because cnt gates every read.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[ptr] <= bus.wr_data_i;
        end
    end

    // Load/run/done sequencer with registered outputs aligned to the run counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= S_LOAD;
            ptr             <= '0;
            c               <= '0;
            for (int l = 0; l < LANES; l++) begin
                cnt[l] <= '0;
            end
            bus.wr_ready_o  <= 1'b0;
            bus.send_o      <= 1'b0;
            bus.data_o      <= '0;
            bus.run_o       <= 1'b0;
            bus.lane_o      <= '0;
            bus.word_o      <= '0;
            bus.lane_mask_o <= '0;
            bus.done_o      <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    bus.done_o     <= 1'b0;
                    bus.wr_ready_o <= 1'b1;
                    if (accept) begin
                        cnt[ptr[5:4]] <= cnt[ptr[5:4]] + 5'd1;
                        ptr           <= ptr + 6'd1;
                        if (ptr == 6'(DEPTH - 1) || bus.wr_last_i) begin
                            state           <= S_RUN;
                            bus.wr_ready_o  <= 1'b0;
                            bus.lane_mask_o <= mask_next;
                            c               <= '0;
                        end
                    end
                end
                S_RUN: begin
                    bus.run_o  <= 1'b1;
                    bus.lane_o <= c_lane;
                    bus.word_o <= c_word;
                    // First 64 cycles present w0..w15; afterwards the expander self-feeds.
                    if (c < 8'(DEPTH)) begin
                        bus.send_o <= 1'b1;
                        bus.data_o <= hit ? rd_word : 32'd0;
                    end else begin
                        bus.send_o <= 1'b0;
                        bus.data_o <= '0;
                    end
                    c <= c + 8'd1;
                    if (c == 8'(RUN_LEN - 1)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    bus.run_o  <= 1'b0;
                    bus.send_o <= 1'b0;
                    bus.data_o <= '0;
                    bus.lane_o <= '0;
                    bus.word_o <= '0;
                    bus.done_o <= 1'b1;
                    ptr        <= '0;
                    for (int l = 0; l < LANES; l++) begin
                        cnt[l] <= '0;
                    end
                    state      <= S_LOAD;
                end
            endcase
        end
    end
endmodule
